// File: rtl/shk_pkg.sv
// Shared constants, state encoding and helpers for the shake arbiter slice.
package shk_pkg;

  localparam int unsigned N_REQ           = 4;
  localparam int unsigned PTR_W           = 2;
  localparam int unsigned WD_SHK_SYNC_DEF = 16;
  localparam int unsigned WD_SHK_DLAY_DEF = 15;
  localparam int unsigned WD_TOUT_DEF     = 16;
  localparam int unsigned TOUT_CYC_DEF    = 4095;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // One-hot requester vector to its index; zero vector maps to 0.
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/shk_rr_arb.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module shk_rr_arb
  import shk_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant_c
);

  logic [PTR_W-1:0] idx;

  // Scan from the farthest slot back towards ptr so the nearest active slot wins.
  always_comb begin
    grant_c = '0;
    idx     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + PTR_W'(i);
      if (req[idx]) grant_c = N_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/shk_arbiter.sv
// Four-way round-robin sharer of one shake master port, one transaction in flight,
// with a watchdog that aborts a target that never answers.
module shk_arbiter
  import shk_pkg::*;
#(
  parameter int unsigned WD_SHK_SYNC = WD_SHK_SYNC_DEF,
  parameter int unsigned WD_SHK_DLAY = WD_SHK_DLAY_DEF,
  parameter int unsigned WD_TOUT     = WD_TOUT_DEF,
  parameter int unsigned TOUT_CYC    = TOUT_CYC_DEF
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,

  input  logic                   s_shk_0_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_0_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_0_dmosi,
  output logic                   s_shk_0_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_0_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_0_dmiso,

  input  logic                   s_shk_1_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_1_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_1_dmosi,
  output logic                   s_shk_1_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_1_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_1_dmiso,

  input  logic                   s_shk_2_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_2_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_2_dmosi,
  output logic                   s_shk_2_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_2_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_2_dmiso,

  input  logic                   s_shk_3_wvalid,
  input  logic [WD_SHK_SYNC-1:0] s_shk_3_smosi,
  input  logic [WD_SHK_DLAY-1:0] s_shk_3_dmosi,
  output logic                   s_shk_3_wready,
  output logic [WD_SHK_SYNC-1:0] s_shk_3_smiso,
  output logic [WD_SHK_DLAY-1:0] s_shk_3_dmiso,

  output logic                   m_shk_wvalid,
  output logic [WD_SHK_SYNC-1:0] m_shk_smosi,
  output logic [WD_SHK_DLAY-1:0] m_shk_dmosi,
  input  logic                   m_shk_wready,
  input  logic [WD_SHK_SYNC-1:0] m_shk_smiso,
  input  logic [WD_SHK_DLAY-1:0] m_shk_dmiso,

  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_tout
);

  logic [N_REQ-1:0]       req_vec;
  logic [WD_SHK_SYNC-1:0] req_smosi [N_REQ];
  logic [WD_SHK_DLAY-1:0] req_dmosi [N_REQ];
  logic [N_REQ-1:0]       arb_grant_c;
  logic [PTR_W-1:0]       arb_idx_c;
  logic                   timeout_c;

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       own_idx;
  logic [WD_TOUT-1:0]     wd_cnt;
  logic [N_REQ-1:0]       resp_wready;
  logic [WD_SHK_SYNC-1:0] resp_smiso [N_REQ];
  logic [WD_SHK_DLAY-1:0] resp_dmiso [N_REQ];

  // Gather the flat requester ports into indexable form.
  assign req_vec      = {s_shk_3_wvalid, s_shk_2_wvalid, s_shk_1_wvalid, s_shk_0_wvalid};
  assign req_smosi[0] = s_shk_0_smosi;
  assign req_smosi[1] = s_shk_1_smosi;
  assign req_smosi[2] = s_shk_2_smosi;
  assign req_smosi[3] = s_shk_3_smosi;
  assign req_dmosi[0] = s_shk_0_dmosi;
  assign req_dmosi[1] = s_shk_1_dmosi;
  assign req_dmosi[2] = s_shk_2_dmosi;
  assign req_dmosi[3] = s_shk_3_dmosi;

  assign s_shk_0_wready = resp_wready[0];
  assign s_shk_1_wready = resp_wready[1];
  assign s_shk_2_wready = resp_wready[2];
  assign s_shk_3_wready = resp_wready[3];
  assign s_shk_0_smiso  = resp_smiso[0];
  assign s_shk_1_smiso  = resp_smiso[1];
  assign s_shk_2_smiso  = resp_smiso[2];
  assign s_shk_3_smiso  = resp_smiso[3];
  assign s_shk_0_dmiso  = resp_dmiso[0];
  assign s_shk_1_dmiso  = resp_dmiso[1];
  assign s_shk_2_dmiso  = resp_dmiso[2];
  assign s_shk_3_dmiso  = resp_dmiso[3];

  shk_rr_arb u_rr_arb (
    .req     (req_vec),
    .ptr     (rr_ptr),
    .grant_c (arb_grant_c)
  );

  assign arb_idx_c = onehot_to_idx(arb_grant_c);
  assign timeout_c = (wd_cnt == WD_TOUT'(TOUT_CYC - 1));

  // Transaction FSM with all outputs registered; a target answer beats a coincident timeout.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      own_idx      <= '0;
      wd_cnt       <= '0;
      m_shk_wvalid <= 1'b0;
      m_shk_smosi  <= '0;
      m_shk_dmosi  <= '0;
      o_grant      <= '0;
      o_tout       <= 1'b0;
      resp_wready  <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        resp_smiso[i] <= '0;
        resp_dmiso[i] <= '0;
      end
    end else begin
      o_tout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_vec) begin
            own_idx      <= arb_idx_c;
            o_grant      <= arb_grant_c;
            m_shk_smosi  <= req_smosi[arb_idx_c];
            m_shk_dmosi  <= req_dmosi[arb_idx_c];
            m_shk_wvalid <= 1'b1;
            wd_cnt       <= '0;
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (m_shk_wready) begin
            resp_wready[own_idx] <= 1'b1;
            resp_smiso[own_idx]  <= m_shk_smiso;
            resp_dmiso[own_idx]  <= m_shk_dmiso;
            m_shk_wvalid         <= 1'b0;
            state                <= ST_RESP;
          end else if (timeout_c) begin
            resp_wready[own_idx] <= 1'b1;
            resp_smiso[own_idx]  <= '0;
            resp_dmiso[own_idx]  <= '0;
            m_shk_wvalid         <= 1'b0;
            o_tout               <= 1'b1;
            state                <= ST_RESP;
          end else if (wd_cnt != {WD_TOUT{1'b1}}) begin
            wd_cnt <= wd_cnt + WD_TOUT'(1);
          end
        end
        ST_RESP: begin
          resp_wready <= '0;
          for (int i = 0; i < N_REQ; i++) begin
            resp_smiso[i] <= '0;
            resp_dmiso[i] <= '0;
          end
          o_grant <= '0;
          rr_ptr  <= own_idx + PTR_W'(1);
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shk_arbiter.sv
// Scoreboard bench for shk_arbiter: transaction-level model predicts grants and
// responses into queues, a negedge monitor pops and compares.
module tb_shk_arbiter;

  localparam int WS   = 16;
  localparam int WDL  = 15;
  localparam int TOUT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           sys_rst;
  logic           wv  [4];
  logic [WS-1:0]  smo [4];
  logic [WDL-1:0] dmo [4];
  logic [3:0]     s_wready;
  logic [WS-1:0]  smi [4];
  logic [WDL-1:0] dmi [4];
  logic           m_wvalid, m_wready;
  logic [WS-1:0]  m_smosi, m_smiso;
  logic [WDL-1:0] m_dmosi, m_dmiso;
  logic [3:0]     o_grant;
  logic           o_tout;

  shk_arbiter #(.WD_SHK_SYNC(WS), .WD_SHK_DLAY(WDL), .WD_TOUT(16), .TOUT_CYC(TOUT)) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .s_shk_0_wvalid(wv[0]), .s_shk_0_smosi(smo[0]), .s_shk_0_dmosi(dmo[0]),
    .s_shk_0_wready(s_wready[0]), .s_shk_0_smiso(smi[0]), .s_shk_0_dmiso(dmi[0]),
    .s_shk_1_wvalid(wv[1]), .s_shk_1_smosi(smo[1]), .s_shk_1_dmosi(dmo[1]),
    .s_shk_1_wready(s_wready[1]), .s_shk_1_smiso(smi[1]), .s_shk_1_dmiso(dmi[1]),
    .s_shk_2_wvalid(wv[2]), .s_shk_2_smosi(smo[2]), .s_shk_2_dmosi(dmo[2]),
    .s_shk_2_wready(s_wready[2]), .s_shk_2_smiso(smi[2]), .s_shk_2_dmiso(dmi[2]),
    .s_shk_3_wvalid(wv[3]), .s_shk_3_smosi(smo[3]), .s_shk_3_dmosi(dmo[3]),
    .s_shk_3_wready(s_wready[3]), .s_shk_3_smiso(smi[3]), .s_shk_3_dmiso(dmi[3]),
    .m_shk_wvalid(m_wvalid), .m_shk_smosi(m_smosi), .m_shk_dmosi(m_dmosi),
    .m_shk_wready(m_wready), .m_shk_smiso(m_smiso), .m_shk_dmiso(m_dmiso),
    .o_grant(o_grant), .o_tout(o_tout)
  );

  typedef struct { int k; logic [WS-1:0] smosi; logic [WDL-1:0] dmosi; int e; } gexp_t;
  typedef struct { int k; logic [WS-1:0] smiso; logic [WDL-1:0] dmiso; bit tout; int e; } rexp_t;
  typedef struct { int lat; logic [WS-1:0] smiso; logic [WDL-1:0] dmiso; } tgt_t;

  gexp_t grant_q[$];
  rexp_t resp_q[$];
  tgt_t  tgt_q[$];
  int    gorder[$];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit rst_edge = 1'b0;
  int ptr = 0;
  int free_at = 0;

  bit         auto_en = 1'b0;
  logic [3:0] auto_mask = 4'h0;
  int         max_gap = 0;
  int         fix_lat = 0;
  bit         fix_req = 1'b0;
  bit         fix_resp = 1'b0;
  bit         go [4];
  int         gap [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h edge=%0d", name, act, exp, edge_n);
    end
  endtask

  // Reference model: a free arbiter takes the first pending requester from ptr;
  // the transaction ends after min(latency, TOUT) cycles and the port is free two edges later.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      rst_edge = sys_rst;
      if (sys_rst) begin
        ptr = 0;
        free_at = edge_n + 1;
        grant_q.delete();
        resp_q.delete();
        tgt_q.delete();
      end else if (edge_n >= free_at && (wv[0] || wv[1] || wv[2] || wv[3])) begin
        int k, lat, done;
        bit tout;
        tgt_t t;
        gexp_t g;
        rexp_t r;
        k = -1;
        for (int i = 0; i < 4; i++) if (k < 0 && wv[(ptr + i) % 4]) k = (ptr + i) % 4;
        lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, TOUT + 3));
        t.lat = lat;
        t.smiso = fix_resp ? 16'hA5A5 : WS'($urandom);
        t.dmiso = WDL'($urandom);
        tgt_q.push_back(t);
        g.k = k; g.smosi = smo[k]; g.dmosi = dmo[k]; g.e = edge_n;
        grant_q.push_back(g);
        tout = (lat > TOUT);
        done = edge_n + (tout ? TOUT : lat);
        r.k = k; r.tout = tout; r.e = done;
        r.smiso = tout ? '0 : t.smiso;
        r.dmiso = tout ? '0 : t.dmiso;
        resp_q.push_back(r);
        ptr = (k + 1) % 4;
        free_at = done + 2;
      end
    end
  end

  // Target: answers the L-th cycle of m_wvalid; noise on the bus otherwise.
  initial begin
    bit   active;
    int   cnt;
    tgt_t cur;
    active = 1'b0; cnt = 0; cur.lat = 0; cur.smiso = '0; cur.dmiso = '0;
    m_wready = 1'b0; m_smiso = '0; m_dmiso = '0;
    forever begin
      @(negedge clk);
      m_wready = 1'b0;
      m_smiso = WS'($urandom);
      m_dmiso = WDL'($urandom);
      if (!m_wvalid) begin
        active = 1'b0;
        m_wready = ($urandom_range(0, 1) == 1);
      end else begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          if (tgt_q.size() > 0) cur = tgt_q.pop_front();
          else cur.lat = 0;
        end
        cnt++;
        if (cnt == cur.lat) begin
          m_wready = 1'b1;
          m_smiso = cur.smiso;
          m_dmiso = cur.dmiso;
        end
      end
    end
  end

  // Requesters: hold wvalid until wready, then re-arm on go or after a random gap.
  initial begin
    for (int k = 0; k < 4; k++) begin
      wv[k] = 1'b0; smo[k] = '0; dmo[k] = '0; gap[k] = 0; go[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (s_wready[k]) begin
          wv[k] = 1'b0;
          gap[k] = int'($urandom_range(0, max_gap));
        end else if (!wv[k]) begin
          if (go[k] || (auto_en && auto_mask[k] && gap[k] == 0)) begin
            wv[k] = 1'b1;
            smo[k] = fix_req ? 16'h0004 : WS'($urandom);
            dmo[k] = fix_req ? 15'h1234 : WDL'($urandom);
          end else if (gap[k] > 0) begin
            gap[k]--;
          end
        end
        go[k] = 1'b0;
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a grant or a response.
  initial begin
    bit    prev_mv, owned;
    gexp_t cg;
    rexp_t r;
    prev_mv = 1'b0; owned = 1'b0;
    cg.k = 0; cg.smosi = '0; cg.dmosi = '0; cg.e = 0;
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        check("rst_ctrl", {22'd0, m_wvalid, o_tout, o_grant, s_wready}, 32'd0);
        check("rst_words", {1'b0, m_smosi | smi[0] | smi[1] | smi[2] | smi[3],
                            m_dmosi | dmi[0] | dmi[1] | dmi[2] | dmi[3]}, 32'd0);
        prev_mv = 1'b0;
        owned = 1'b0;
        continue;
      end
      if (m_wvalid && !prev_mv) begin
        if (grant_q.size() == 0) begin
          check("unexpected_grant", {28'd0, o_grant}, 32'd0);
          owned = 1'b0;
        end else begin
          cg = grant_q.pop_front();
          owned = 1'b1;
          gorder.push_back(cg.k);
          check("grant_edge", edge_n, cg.e);
        end
      end
      if (m_wvalid && owned) begin
        check("o_grant", {28'd0, o_grant}, 32'd1 << cg.k);
        check("m_smosi", {16'd0, m_smosi}, {16'd0, cg.smosi});
        check("m_dmosi", {17'd0, m_dmosi}, {17'd0, cg.dmosi});
      end
      if (!m_wvalid && s_wready == 4'd0 && !o_tout) check("idle_grant", {28'd0, o_grant}, 32'd0);
      if (s_wready != 4'd0 || o_tout) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", {27'd0, s_wready, o_tout}, 32'd0);
        end else begin
          r = resp_q.pop_front();
          owned = 1'b0;
          check("resp_edge", edge_n, r.e);
          check("wready_vec", {28'd0, s_wready}, 32'd1 << r.k);
          check("o_tout", {31'd0, o_tout}, {31'd0, r.tout});
          check("m_wvalid_low", {31'd0, m_wvalid}, 32'd0);
          check("smiso", {16'd0, smi[r.k]}, {16'd0, r.smiso});
          check("dmiso", {17'd0, dmi[r.k]}, {17'd0, r.dmiso});
          for (int j = 0; j < 4; j++)
            if (j != r.k) check("other_words", {1'b0, smi[j], dmi[j]}, 32'd0);
        end
      end
      prev_mv = m_wvalid;
    end
  end

  task automatic pulse_go(input logic [3:0] mask);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (mask[k]) go[k] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 sys_rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 sys_rst = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < max_cyc) begin
      @(negedge clk);
      #2;
      n++;
      idle = (grant_q.size() == 0) && (resp_q.size() == 0) && !m_wvalid &&
             !wv[0] && !wv[1] && !wv[2] && !wv[3];
    end
    check("wait_done", {31'd0, idle}, 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout actual=running required=finished edge=%0d", edge_n);
    $fatal(1, "bench time limit");
  end

  initial begin
    sys_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 sys_rst = 1'b0;

    // Single request from 2 with fixed words, target answers on the 5th cycle.
    fix_req = 1'b1; fix_resp = 1'b1; fix_lat = 5;
    gorder.delete();
    pulse_go(4'b0100);
    wait_done(100);
    check("t1_count", gorder.size(), 32'd1);
    check("t1_owner", (gorder.size() > 0) ? gorder[0] : -1, 32'd2);
    fix_req = 1'b0; fix_resp = 1'b0;

    // All four requesting back to back with a 1-cycle target.
    do_reset();
    fix_lat = 1; max_gap = 0; auto_mask = 4'hF; auto_en = 1'b1;
    gorder.delete();
    for (int i = 0; i < 200 && gorder.size() < 8; i++) @(negedge clk);
    #1 auto_en = 1'b0;
    wait_done(100);
    for (int i = 0; i < 8; i++)
      check("t2_order", (i < gorder.size()) ? gorder[i] : -1, i % 4);

    // Pointer at 2 after serving 1; then 1 and 3 together -> 3 first.
    do_reset();
    pulse_go(4'b0010);
    wait_done(50);
    gorder.delete();
    pulse_go(4'b1010);
    wait_done(50);
    check("t3_first", (gorder.size() > 0) ? gorder[0] : -1, 32'd3);
    check("t3_second", (gorder.size() > 1) ? gorder[1] : -1, 32'd1);

    // Answer on the exact timeout cycle, then a target that never answers.
    fix_lat = TOUT;
    pulse_go(4'b0100);
    wait_done(50);
    fix_lat = 100;
    pulse_go(4'b0001);
    wait_done(50);

    // Reset while BUSY; the still-held request is granted again afterwards.
    fix_lat = 100;
    gorder.delete();
    pulse_go(4'b0001);
    repeat (3) @(negedge clk);
    #1 sys_rst = 1'b1;
    @(negedge clk);
    #1 fix_lat = 2;
    sys_rst = 1'b0;
    wait_done(50);
    check("t5_regrant", gorder.size(), 32'd2);

    // Randomized traffic, latencies spanning both sides of the timeout.
    fix_lat = 0; max_gap = 6; auto_mask = 4'hF; auto_en = 1'b1;
    repeat (1500) @(posedge clk);
    #1 auto_en = 1'b0;
    wait_done(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
